cmp_pipe_mag: RTL and testbench

- Parametrised, pipelined magnitude comparator. Successor to the team's 2-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, resolving CHUNK bits per pipeline stage, in either unsigned or two's-complement mode.
- Streaming valid/ready interface on both sides, so it drops into datapaths that need greater/equal/less flags at full clock rate.

---
 rtl/cmp_pipe_mag.sv | 111 +++++++++++
 tb/tb_cmp_pipe_mag.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_pipe_mag.sv
// Pipelined magnitude comparator: resolves CHUNK bits per stage, MSB-first,
// in unsigned or two's-complement mode, with valid/ready on both sides.
module cmp_pipe_mag #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_greater,
  output logic             out_equal,
  output logic             out_less
);

  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic             last_v;
  logic             last_gt;
  logic             last_lt;

  // Handshake: in_valid&in_ready accepts on a rising edge, out_valid&out_ready
  // pops on a rising edge; the whole pipe moves together only when advance=1.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_m = {in_a[WIDTH-1] ^ in_signed, in_a[WIDTH-2:0]};
  assign b_m = {in_b[WIDTH-1] ^ in_signed, in_b[WIDTH-2:0]};

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int SRC = WIDTH - s * CHUNK;
    localparam int REM = SRC - CHUNK;

    logic [SRC-1:0]   src_a;
    logic [SRC-1:0]   src_b;
    logic             src_v;
    logic             src_gt;
    logic             src_lt;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic             v_r;
    logic             gt_r;
    logic             lt_r;

    if (s == 0) begin : g_src
      assign src_a  = a_m;
      assign src_b  = b_m;
      assign src_v  = in_valid;
      assign src_gt = 1'b0;
      assign src_lt = 1'b0;
    end else begin : g_src
      assign src_a  = g_stage[s-1].g_rem.a_r;
      assign src_b  = g_stage[s-1].g_rem.b_r;
      assign src_v  = g_stage[s-1].v_r;
      assign src_gt = g_stage[s-1].gt_r;
      assign src_lt = g_stage[s-1].lt_r;
    end

    assign a_c = src_a[SRC-1 -: CHUNK];
    assign b_c = src_b[SRC-1 -: CHUNK];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_r  <= 1'b0;
        gt_r <= 1'b0;
        lt_r <= 1'b0;
      end else if (advance) begin
        v_r <= src_v;
        if (src_gt | src_lt) begin
          gt_r <= src_gt;
          lt_r <= src_lt;
        end else begin
          gt_r <= (a_c > b_c);
          lt_r <= (a_c < b_c);
        end
      end
    end

    // Only the still-unresolved low bits travel on; the last stage keeps none.
    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_r;
      logic [REM-1:0] b_r;

      always_ff @(posedge clk) begin
        if (advance) begin
          a_r <= src_a[REM-1:0];
          b_r <= src_b[REM-1:0];
        end
      end
    end
  end

  assign last_v  = g_stage[STAGES-1].v_r;
  assign last_gt = g_stage[STAGES-1].gt_r;
  assign last_lt = g_stage[STAGES-1].lt_r;

  assign out_valid   = last_v;
  assign out_greater = last_v & last_gt;
  assign out_less    = last_v & last_lt;
  assign out_equal   = last_v & ~last_gt & ~last_lt;

endmodule

// File: tb/tb_cmp_pipe_mag.sv
// Bench for cmp_pipe_mag: a 16/4 instance with directed and streaming tests
// and an 8/8 single-stage instance with a random regression.
module tb_cmp_pipe_mag;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic        out_greater, out_equal, out_less;
  logic [15:0] in_a, in_b;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
  logic        out_greater8, out_equal8, out_less8;
  logic [7:0]  in_a8, in_b8;

  int passed;
  int total;
  int pops16;

  logic [2:0] exp_q[$];
  logic [2:0] exp8_q[$];

  cmp_pipe_mag #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_greater(out_greater), .out_equal(out_equal), .out_less(out_less)
  );

  cmp_pipe_mag #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_signed(in_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_greater(out_greater8), .out_equal(out_equal8), .out_less(out_less8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] model16(input logic [15:0] a, input logic [15:0] b,
                                         input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return {gt, ~gt & ~lt, lt};
  endfunction

  function automatic logic [2:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return {gt, ~gt & ~lt, lt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic s);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s);
    in_valid8  = 1'b1;
    in_a8      = a;
    in_b8      = b;
    in_signed8 = s;
  endtask

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        pops16++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out16", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("flags16", {out_greater, out_equal, out_less}, e);
          chk("onehot16", $countones({out_greater, out_equal, out_less}), 1);
        end
      end
      if (!out_valid) chk("idle16", {out_greater, out_equal, out_less}, 0);
      if (in_valid && in_ready) exp_q.push_back(model16(in_a, in_b, in_signed));

      if (out_valid8 && out_ready8) begin
        if (exp8_q.size() == 0) begin
          chk("unexpected_out8", 1, 0);
        end else begin
          e = exp8_q.pop_front();
          chk("flags8", {out_greater8, out_equal8, out_less8}, e);
        end
      end
      if (in_valid8 && in_ready8) exp8_q.push_back(model8(in_a8, in_b8, in_signed8));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] pa [8];
    logic [15:0] pb [8];
    logic        ps [8];
    int          idx;
    int          pops_start;
    logic        fired;

    passed = 0; total = 0; pops16 = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; out_ready8 = 1'b1;

    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {out_greater, out_equal, out_less}, 0);
    chk("rst_valid8", out_valid8, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // unsigned vs signed on the same pair, with latency tracking
    drive(16'h8000, 16'h7FFF, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("lat_e0", out_valid, 0);
    tick(); chk("lat_e1", out_valid, 0);
    tick(); chk("lat_e2", out_valid, 0);
    tick(); chk("lat_e3", out_valid, 1);
    chk("u_8000_gt", out_greater, 1);

    drive(16'h8000, 16'h7FFF, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("bubble_after_pop", out_valid, 0);
    tick(); tick(); tick();
    chk("s_8000_valid", out_valid, 1);
    chk("s_8000_lt", out_less, 1);

    // three consecutive: equal, low-chunk less, low-chunk greater
    drive(16'h1234, 16'h1234, 1'b0); tick();
    drive(16'h1230, 16'h1231, 1'b0); tick();
    drive(16'hFFFF, 16'hFFFE, 1'b0); tick();
    in_valid = 1'b0;
    tick(); chk("seq_eq", {out_valid, out_equal}, 2'b11);
    tick(); chk("seq_lt", {out_valid, out_less}, 2'b11);
    tick(); chk("seq_gt", {out_valid, out_greater}, 2'b11);
    tick(); chk("seq_bubble", out_valid, 0);

    // signed extremes
    drive(16'hFFFF, 16'h0001, 1'b1); tick();
    drive(16'h8000, 16'h7FFF, 1'b1); tick();
    drive(16'h0000, 16'hFFFF, 1'b1); tick();
    in_valid = 1'b0;
    tick(); chk("sx_m1_lt", {out_valid, out_less}, 2'b11);
    tick(); chk("sx_min_lt", {out_valid, out_less}, 2'b11);
    tick(); chk("sx_0_gt", {out_valid, out_greater}, 2'b11);
    tick();

    // backpressure with a 3-cycle stall mid-stream
    for (int i = 0; i < 8; i++) begin
      pa[i] = 16'($urandom_range(0, 65535));
      pb[i] = (i % 3 == 0) ? {pa[i][15:4], 4'($urandom_range(0, 15))}
                           : 16'($urandom_range(0, 65535));
      ps[i] = 1'($urandom_range(0, 1));
    end
    pops_start = pops16;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      out_ready = (c >= 5 && c < 8) ? 1'b0 : 1'b1;
      drive(pa[idx], pb[idx], ps[idx]);
      #1;
      if (c >= 5 && c < 8) begin
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
      end
      fired = in_valid && in_ready;
      tick();
      if (fired) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", idx, 8);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_count", pops16 - pops_start, 8);

    // reset mid-flight with results held under backpressure
    out_ready = 1'b0;
    drive(16'h0001, 16'h0002, 1'b0); tick();
    drive(16'h0003, 16'h0002, 1'b0); tick();
    drive(16'h0004, 16'h0004, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    chk("rmf_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rmf_valid", out_valid, 0);
    chk("rmf_flags", {out_greater, out_equal, out_less}, 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("rmf_no_stale", out_valid, 0);
      tick();
    end
    drive(16'h7000, 16'h7001, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("rmf_lat0", out_valid, 0);
    tick(); chk("rmf_lat1", out_valid, 0);
    tick(); chk("rmf_lat2", out_valid, 0);
    tick(); chk("rmf_lat3", {out_valid, out_less}, 2'b11);
    tick();

    // random streaming regression with random bubbles and backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = 16'($urandom_range(0, 65535));
      in_b      = ($urandom_range(0, 4) == 0) ? in_a : 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) in_b[15:8] = in_a[15:8];
      in_signed = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) tick();
    chk("rand16_drain", exp_q.size(), 0);

    // single-stage build
    drive8(8'h05, 8'h05, 1'b0);
    tick();
    in_valid8 = 1'b0;
    chk("w8_eq_next", {out_valid8, out_equal8}, 2'b11);
    tick();
    chk("w8_bubble", out_valid8, 0);

    for (int i = 0; i < 1000; i++) begin
      in_valid8  = 1'b1;
      in_a8      = 8'($urandom_range(0, 255));
      in_b8      = (i % 4 == 0) ? in_a8 : 8'($urandom_range(0, 255));
      in_signed8 = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid8 = 1'b0;
    for (int k = 0; k < 5 && exp8_q.size() > 0; k++) tick();
    chk("rand8_drain", exp8_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
